// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and port-id encoding for the data-memory arbiter and the data memory.
// Combinational grant, one-cycle read return, one access per clock.
package dmem_arbiter_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_ADDR_WIDTH = 10;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     vld;
        port_id_t port;
    } rd_pend_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's access channel: request/address/data toward the arbiter, grant and read return back.
// Request is held until gnt; read data returns one cycle after the grant.
interface dmem_arbiter_if #(
    parameter int data_WIDTH = dmem_arbiter_pkg::DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = dmem_arbiter_pkg::DMEM_ADDR_WIDTH
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [data_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [data_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-winner register; grant is combinational from req.
// No backpressure of its own: a lone requester wins at once, a tie goes to the port that lost last.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_any,
    output port_id_t   winner
);

    port_id_t last_gnt;

    // Grants are suppressed while reset is asserted so nothing reaches the memory.
    always_comb begin
        winner  = PORT0;
        gnt_any = 1'b0;
        if (rst_n) begin
            case (req)
                2'b01: begin
                    winner  = PORT0;
                    gnt_any = 1'b1;
                end
                2'b10: begin
                    winner  = PORT1;
                    gnt_any = 1'b1;
                end
                2'b11: begin
                    winner  = other_port(last_gnt);
                    gnt_any = 1'b1;
                end
                default: ;
            endcase
        end
        gnt[0] = gnt_any && (winner == PORT0);
        gnt[1] = gnt_any && (winner == PORT1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT1;
        end else if (gnt_any) begin
            last_gnt <= winner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters; grant same cycle, read data next cycle.
// Full throughput: one access per clock, losing port simply holds its request.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int data_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [data_WIDTH-1:0] mem_in,
    output logic                  mem_we,
    input  logic [data_WIDTH-1:0] mem_out
);

    logic [1:0]            gnt;
    logic                  gnt_any;
    port_id_t              winner;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [data_WIDTH-1:0] win_wdata;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [data_WIDTH-1:0] held_wdata;
    rd_pend_t              pend;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({p1.req, p0.req}),
        .gnt     (gnt),
        .gnt_any (gnt_any),
        .winner  (winner)
    );

    assign p0.gnt = gnt[0];
    assign p1.gnt = gnt[1];

    always_comb begin
        win_we    = p0.we;
        win_addr  = p0.addr;
        win_wdata = p0.wdata;
        if (winner == PORT1) begin
            win_we    = p1.we;
            win_addr  = p1.addr;
            win_wdata = p1.wdata;
        end
    end

    // Idle cycles keep presenting the last granted access so the memory bus stays quiet.
    assign mem_address = gnt_any ? win_addr  : held_addr;
    assign mem_in      = gnt_any ? win_wdata : held_wdata;
    assign mem_we      = gnt_any && win_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr  <= '0;
            held_wdata <= '0;
        end else if (gnt_any) begin
            held_addr  <= win_addr;
            held_wdata <= win_wdata;
        end
    end

    // Memory returns read data one cycle after the address; remember who asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.vld  <= 1'b0;
            pend.port <= PORT0;
        end else begin
            pend.vld  <= gnt_any && !win_we;
            pend.port <= winner;
        end
    end

    assign p0.rvalid = pend.vld && (pend.port == PORT0);
    assign p1.rvalid = pend.vld && (pend.port == PORT1);
    assign p0.rdata  = p0.rvalid ? mem_out : '0;
    assign p1.rdata  = p1.rvalid ? mem_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic against a reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  mem_address;
    logic [31:0] mem_in;
    logic        mem_we;
    logic [31:0] mem_out;

    logic        s_req   [2];
    logic        s_we    [2];
    logic [9:0]  s_addr  [2];
    logic [31:0] s_wdata [2];

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    assign p0_if.req   = s_req[0];
    assign p0_if.we    = s_we[0];
    assign p0_if.addr  = s_addr[0];
    assign p0_if.wdata = s_wdata[0];
    assign p1_if.req   = s_req[1];
    assign p1_if.we    = s_we[1];
    assign p1_if.addr  = s_addr[1];
    assign p1_if.wdata = s_wdata[1];

    dmem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0          (p0_if),
        .p1          (p1_if),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_we      (mem_we),
        .mem_out     (mem_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'd2001;
        if (i == 1) return 32'd4001;
        if (i == 2) return 32'd5001;
        return 32'(i * 7 + 100);
    endfunction

    // Behavioural data memory: registered read, output held on write cycles, contents reloaded in reset.
    logic [31:0] dmem [1024];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
        end else if (mem_we) begin
            dmem[mem_address] <= mem_in;
        end else begin
            mem_out <= dmem[mem_address];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    int          ref_last;
    logic [9:0]  ref_haddr;
    logic [31:0] ref_hdata;
    logic        exp_rd_vld;
    int          exp_rd_port;
    logic [31:0] exp_rd_data;

    int          last_w;
    logic        cap_we;
    logic [31:0] cap_rdata [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_req(input int p);
        s_req[p]   = 1'b1;
        s_we[p]    = 1'($urandom_range(0, 1));
        s_addr[p]  = 10'($urandom_range(0, 7));
        s_wdata[p] = $urandom;
    endtask

    // Called just after a rising edge with stimulus already applied; checks one cycle, advances the model.
    task automatic run_cycle();
        int w;
        w = -1;
        if (s_req[0] && s_req[1]) w = 1 - ref_last;
        else if (s_req[0])        w = 0;
        else if (s_req[1])        w = 1;
        @(negedge clk);
        chk("p0_gnt", 64'(p0_if.gnt), 64'(w == 0));
        chk("p1_gnt", 64'(p1_if.gnt), 64'(w == 1));
        chk("mem_we", 64'(mem_we), 64'((w >= 0) ? s_we[w] : 1'b0));
        chk("mem_address", 64'(mem_address), 64'((w >= 0) ? s_addr[w] : ref_haddr));
        chk("mem_in", 64'(mem_in), 64'((w >= 0) ? s_wdata[w] : ref_hdata));
        chk("p0_rvalid", 64'(p0_if.rvalid), 64'(exp_rd_vld && exp_rd_port == 0));
        chk("p1_rvalid", 64'(p1_if.rvalid), 64'(exp_rd_vld && exp_rd_port == 1));
        chk("p0_rdata", 64'(p0_if.rdata), 64'((exp_rd_vld && exp_rd_port == 0) ? exp_rd_data : 32'd0));
        chk("p1_rdata", 64'(p1_if.rdata), 64'((exp_rd_vld && exp_rd_port == 1) ? exp_rd_data : 32'd0));
        cap_we       = mem_we;
        cap_rdata[0] = p0_if.rdata;
        cap_rdata[1] = p1_if.rdata;
        @(posedge clk);
        #1;
        exp_rd_vld = 1'b0;
        if (w >= 0) begin
            ref_last  = w;
            ref_haddr = s_addr[w];
            ref_hdata = s_wdata[w];
            if (s_we[w]) begin
                ref_mem[s_addr[w]] = s_wdata[w];
            end else begin
                exp_rd_vld  = 1'b1;
                exp_rd_port = w;
                exp_rd_data = ref_mem[s_addr[w]];
            end
            s_req[w] = 1'b0;
        end
        last_w = w;
    endtask

    // Called just after a rising edge; holds reset across one edge and releases it mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        ref_last   = 1;
        ref_haddr  = '0;
        ref_hdata  = '0;
        exp_rd_vld = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        @(negedge clk);
        chk("rst_p0_gnt", 64'(p0_if.gnt), 64'd0);
        chk("rst_p1_gnt", 64'(p1_if.gnt), 64'd0);
        chk("rst_p0_rvalid", 64'(p0_if.rvalid), 64'd0);
        chk("rst_p1_rvalid", 64'(p1_if.rvalid), 64'd0);
        chk("rst_p0_rdata", 64'(p0_if.rdata), 64'd0);
        chk("rst_p1_rdata", 64'(p1_if.rdata), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_mem_in", 64'(mem_in), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt [2];
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            s_req[p] = 1'b0; s_we[p] = 1'b0; s_addr[p] = '0; s_wdata[p] = '0;
        end
        @(posedge clk);
        #1;
        s_req[1] = 1'b1;  // a request held during reset must not be granted
        do_reset();
        s_req[1] = 1'b0;

        // Lone p0 read of address 0
        s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 10'd0;
        run_cycle();
        chk("t1_grant_port", 64'(last_w), 64'd0);
        run_cycle();
        chk("t1_p0_rdata", 64'(cap_rdata[0]), 64'd2001);

        // Simultaneous reads: p0 first after reset, then p1
        @(posedge clk); #1;
        do_reset();
        s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 10'd1;
        s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 10'd2;
        run_cycle();
        chk("t2_first_grant", 64'(last_w), 64'd0);
        run_cycle();
        chk("t2_second_grant", 64'(last_w), 64'd1);
        chk("t2_p0_rdata", 64'(cap_rdata[0]), 64'd4001);
        run_cycle();
        chk("t2_p1_rdata", 64'(cap_rdata[1]), 64'd5001);

        // p1 write then read of the same address
        s_req[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'd3; s_wdata[1] = 32'h0000ABCD;
        run_cycle();
        chk("t3_write_we", 64'(cap_we), 64'd1);
        s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 10'd3;
        run_cycle();
        chk("t3_read_we", 64'(cap_we), 64'd0);
        run_cycle();
        chk("t3_p1_rdata", 64'(cap_rdata[1]), 64'h0000ABCD);
        chk("t3_idle_we", 64'(cap_we), 64'd0);

        // Continuous contention for 8 cycles
        @(posedge clk); #1;
        do_reset();
        cnt[0] = 0; cnt[1] = 0;
        new_req(0);
        new_req(1);
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            chk("t4_alternate", 64'(last_w), 64'(i % 2));
            if (last_w >= 0) begin
                cnt[last_w]++;
                new_req(last_w);
            end
        end
        chk("t4_p0_count", 64'(cnt[0]), 64'd4);
        chk("t4_p1_count", 64'(cnt[1]), 64'd4);
        s_req[0] = 1'b0; s_req[1] = 1'b0;
        run_cycle();

        // Reset with a read in flight
        s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 10'd5;
        run_cycle();
        chk("t5_grant_port", 64'(last_w), 64'd0);
        s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 10'd6;
        do_reset();
        run_cycle();
        chk("t5_post_reset_grant", 64'(last_w), 64'd1);
        s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 10'd7;
        s_req[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'd7; s_wdata[1] = 32'h1234_5678;
        run_cycle();
        chk("t5_tie_after_p1", 64'(last_w), 64'd0);
        run_cycle();

        // Randomized traffic on a small address window to force collisions and reuse
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!s_req[p] && ($urandom_range(0, 2) != 0)) new_req(p);
            end
            run_cycle();
        end
        s_req[0] = 1'b0; s_req[1] = 1'b0;
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
